// File: rtl/iir_pkg.sv
// Shared definitions for the IIR notch chain and its coefficient loader.
//   - notch select codes, coefficient set geometry (NUM + DEN words)
//   - loader status and state encodings
//   - notch_strobe(): one-hot write strobe for a select code
package iir_pkg;

  localparam int unsigned NUM         = 3;
  localparam int unsigned DEN         = 2;
  localparam int unsigned COEFF_DEPTH = NUM + DEN;

  typedef enum logic [1:0] {
    NOTCH_1MHZ    = 2'b00,
    NOTCH_2MHZ    = 2'b01,
    NOTCH_2_4MHZ  = 2'b10,
    NOTCH_INVALID = 2'b11
  } notch_sel_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_MISMATCH = 2'b01,
    ST_BAD_SEL  = 2'b10,
    ST_TIMEOUT  = 2'b11
  } load_status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_COMMIT  = 3'd2,
    S_VERIFY  = 3'd3,
    S_DONE    = 3'd4
  } loader_state_e;

  // Strobe vector bit order: [0] 1 MHz, [1] 2 MHz, [2] 2.4 MHz.
  function automatic logic [2:0] notch_strobe(input notch_sel_e sel);
    logic [2:0] stb;
    stb = 3'b000;
    case (sel)
      NOTCH_1MHZ:   stb = 3'b001;
      NOTCH_2MHZ:   stb = 3'b010;
      NOTCH_2_4MHZ: stb = 3'b100;
      default:      stb = 3'b000;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/iir_coeff_loader.sv
// Coefficient programming front-end for the IIR notch chain.
// Collects a five-word frame over cfg_valid/cfg_ready, writes it to the
// selected notch filter with a one-cycle strobe, reads it back and reports
// a status with a one-cycle load_done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      host word handshake
//   cfg_sel                  target notch, sampled with word 0
//   cfg_data                 coefficient word (signed Q2.18)
//   coeff_wr_data            shadow coefficient set, fanned to all filters
//   coeff_wr_en_*            one-cycle write strobes
//   coeff_rd_*               readback from each filter
//   load_done, load_status   completion pulse and held status
//   busy                     high outside IDLE
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH    = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_sel,
  input  logic signed [COEFF_WIDTH-1:0] cfg_data,
  output logic signed [COEFF_WIDTH-1:0] coeff_wr_data [COEFF_DEPTH],
  output logic                          coeff_wr_en_1MHz,
  output logic                          coeff_wr_en_2MHz,
  output logic                          coeff_wr_en_2_4MHz,
  input  logic signed [COEFF_WIDTH-1:0] coeff_rd_1MHz [COEFF_DEPTH],
  input  logic signed [COEFF_WIDTH-1:0] coeff_rd_2MHz [COEFF_DEPTH],
  input  logic signed [COEFF_WIDTH-1:0] coeff_rd_2_4MHz [COEFF_DEPTH],
  output logic                          load_done,
  output logic [1:0]                    load_status,
  output logic                          busy
);

  localparam int unsigned CNT_W  = $clog2(COEFF_DEPTH);
  localparam int unsigned STG_N  = COEFF_DEPTH - 1;
  localparam int unsigned STG_W  = $clog2(STG_N);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(COEFF_DEPTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  loader_state_e                 state_q;
  notch_sel_e                    sel_q;
  logic                          bad_sel_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [IDLE_W-1:0]             idle_q;
  logic signed [COEFF_WIDTH-1:0] stage_q  [STG_N];
  logic signed [COEFF_WIDTH-1:0] shadow_q [COEFF_DEPTH];
  logic [2:0]                    wr_en_q;
  logic                          done_q;
  load_status_e                  status_q;
  logic                          ready_q;
  logic                          busy_q;

  logic                          accept_c;
  logic signed [COEFF_WIDTH-1:0] rd_sel_c [COEFF_DEPTH];
  logic                          mismatch_c;

  // cfg_ready is a register, so accept never depends combinationally on itself.
  assign accept_c = cfg_valid && ready_q;

  // Readback of the latched target compared bit-exact against the shadow set.
  always_comb begin
    rd_sel_c   = coeff_rd_1MHz;
    mismatch_c = 1'b0;
    case (sel_q)
      NOTCH_2MHZ:   rd_sel_c = coeff_rd_2MHz;
      NOTCH_2_4MHZ: rd_sel_c = coeff_rd_2_4MHz;
      default:      rd_sel_c = coeff_rd_1MHz;
    endcase
    for (int i = 0; i < int'(COEFF_DEPTH); i++) begin
      if (rd_sel_c[i] != shadow_q[i]) mismatch_c = 1'b1;
    end
  end

  // Loader FSM with registered outputs. Words 0..3 land in a staging buffer
  // and only a complete, well-addressed frame reaches the shadow set, so a
  // timed-out or bad-select frame leaves coeff_wr_data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= NOTCH_1MHZ;
      bad_sel_q <= 1'b0;
      cnt_q     <= '0;
      idle_q    <= '0;
      for (int i = 0; i < int'(STG_N); i++) stage_q[i] <= '0;
      for (int i = 0; i < int'(COEFF_DEPTH); i++) shadow_q[i] <= '0;
      wr_en_q   <= 3'b000;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 3'b000;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            stage_q[0] <= cfg_data;
            sel_q      <= notch_sel_e'(cfg_sel);
            bad_sel_q  <= (cfg_sel == NOTCH_INVALID);
            cnt_q      <= CNT_W'(1);
            idle_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (accept_c) begin
            idle_q <= '0;
            if (cnt_q == LAST_IDX) begin
              cnt_q   <= '0;
              ready_q <= 1'b0;
              if (bad_sel_q) begin
                done_q   <= 1'b1;
                status_q <= ST_BAD_SEL;
                state_q  <= S_DONE;
              end else begin
                for (int i = 0; i < int'(STG_N); i++) shadow_q[i] <= stage_q[i];
                shadow_q[COEFF_DEPTH-1] <= cfg_data;
                wr_en_q <= notch_strobe(sel_q);
                state_q <= S_COMMIT;
              end
            end else begin
              stage_q[cnt_q[STG_W-1:0]] <= cfg_data;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (idle_q == IDLE_LIMIT) begin
            // Partial frame dropped; no strobe issued.
            cnt_q    <= '0;
            idle_q   <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b1;
            status_q <= ST_TIMEOUT;
            state_q  <= S_DONE;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end
        S_COMMIT: begin
          state_q <= S_VERIFY;
        end
        S_VERIFY: begin
          // Filters latched the set on the strobe edge, readback is valid now.
          done_q   <= 1'b1;
          status_q <= mismatch_c ? ST_MISMATCH : ST_OK;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready          = ready_q;
  assign busy               = busy_q;
  assign coeff_wr_data      = shadow_q;
  assign coeff_wr_en_1MHz   = wr_en_q[0];
  assign coeff_wr_en_2MHz   = wr_en_q[1];
  assign coeff_wr_en_2_4MHz = wr_en_q[2];
  assign load_done          = done_q;
  assign load_status        = status_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: the driver pushes the expected
// completion of each frame, a negedge monitor pops and checks it on load_done.
module tb_iir_coeff_loader;
  import iir_pkg::*;

  typedef struct packed {
    logic [1:0]       status;
    logic [2:0]       mask;
    logic [11:0]      lat;
    logic             chk_sh;
    logic [4:0][19:0] sh;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, load_done, busy;
  logic [1:0] cfg_sel, load_status;
  logic signed [19:0] cfg_data;
  logic signed [19:0] wr_data [5];
  logic signed [19:0] f1 [5], f2 [5], f24 [5];
  logic signed [19:0] rd1 [5], rd2 [5], rd24 [5];
  logic en1, en2, en24;
  logic corrupt;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [4:0][19:0] FA, FB, FC, FD, FE, Z;

  always #5 clk = ~clk;

  iir_coeff_loader dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .coeff_wr_data(wr_data),
    .coeff_wr_en_1MHz(en1), .coeff_wr_en_2MHz(en2), .coeff_wr_en_2_4MHz(en24),
    .coeff_rd_1MHz(rd1), .coeff_rd_2MHz(rd2), .coeff_rd_2_4MHz(rd24),
    .load_done(load_done), .load_status(load_status), .busy(busy)
  );

  // Filter models: register the set on their strobe edge.
  initial for (int i = 0; i < 5; i++) begin f1[i] = '0; f2[i] = '0; f24[i] = '0; end
  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (en1)  f1[i]  <= wr_data[i];
      if (en2)  f2[i]  <= wr_data[i];
      if (en24) f24[i] <= wr_data[i];
    end
  end
  always_comb begin
    rd1 = f1;
    rd2 = f2;
    rd24 = f24;
    if (corrupt) rd24[3] = f24[3] ^ 20'sh00001;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] st, input logic [2:0] m, input int lat,
                      input logic c, input logic [4:0][19:0] sh);
    exp_t e;
    e.status = st; e.mask = m; e.lat = 12'(lat); e.chk_sh = c; e.sh = sh;
    q.push_back(e);
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [1:0] s, input logic [19:0] d);
    int g;
    g = 0;
    cfg_valid = 1'b1; cfg_sel = s; cfg_data = d;
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      g++;
      if (g > 20) begin
        total++; bad++;
        $display("FAIL send_word: cfg_ready stuck at %0d, required 1", cfg_ready);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [1:0] s, input logic [4:0][19:0] f, input int n);
    for (int i = 0; i < n; i++) send_word(s, f[i]);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d completions outstanding, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobes"}, {en24, en2, en1}, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_status"}, load_status, 0);
    for (int i = 0; i < 5; i++) check({tag, "_wrdata"}, $unsigned(wr_data[i]), 0);
  endtask

  // Monitor: tracks strobes and accept-to-done latency, checks each completion.
  initial begin : monitor
    logic [2:0] seen, stb;
    int nstb, since;
    exp_t e;
    seen = 0; nstb = 0; since = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0; nstb = 0; since = 0;
      end else begin
        if (cfg_valid && cfg_ready) since = 0; else since++;
        stb = {en24, en2, en1};
        if (stb != 3'b000) begin
          check("strobe_onehot", $countones(stb), 1);
          check("ready_in_commit", cfg_ready, 0);
          seen = seen | stb;
          nstb++;
        end
        if (load_done) begin
          check("ready_in_done", cfg_ready, 0);
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: status %0d with no frame pending", load_status);
          end else begin
            e = q.pop_front();
            check("status", load_status, e.status);
            check("strobe_mask", seen, e.mask);
            check("strobe_count", nstb, (e.mask != 0) ? 1 : 0);
            check("latency", since, e.lat);
            if (e.chk_sh)
              for (int i = 0; i < 5; i++) check("shadow", $unsigned(wr_data[i]), e.sh[i]);
          end
          seen = 0; nstb = 0;
        end
      end
    end
  end

  initial begin
    FA = {20'h00F00, 20'h3FE80, 20'h00100, 20'h3FF00, 20'h00100};
    FB = {20'h00A00, 20'h3FD00, 20'h00200, 20'h3FC00, 20'h00200};
    FC = {20'h00C00, 20'h3FF40, 20'h00080, 20'h3FF80, 20'h00080};
    FD = {20'h55555, 20'h44444, 20'h33333, 20'h22222, 20'h11111};
    FE = {20'h00700, 20'h3FE00, 20'h00300, 20'h3FA00, 20'h00300};
    Z  = '0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_sel = 2'b00; cfg_data = '0; corrupt = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Good 1 MHz load
    push(ST_OK, 3'b001, 3, 1'b1, FA);
    send_frame(2'b00, FA, 5); cfg_valid = 1'b0;
    wait_drain();

    // Readback mismatch on the 2.4 MHz filter, word 3
    corrupt = 1'b1;
    push(ST_MISMATCH, 3'b100, 3, 1'b1, FC);
    send_frame(2'b10, FC, 5); cfg_valid = 1'b0;
    wait_drain();
    corrupt = 1'b0;

    // Bad select frame fully consumed, then a good 2 MHz frame
    push(ST_BAD_SEL, 3'b000, 1, 1'b1, FC);
    send_frame(2'b11, FD, 5); cfg_valid = 1'b0;
    push(ST_OK, 3'b010, 3, 1'b1, FB);
    send_frame(2'b01, FB, 5); cfg_valid = 1'b0;
    wait_drain();

    // Timeout after two words: 1024 idle cycles, shadow keeps FB
    push(ST_TIMEOUT, 3'b000, 1025, 1'b1, FB);
    send_frame(2'b00, FE, 2); cfg_valid = 1'b0;
    wait_drain();

    // Back-to-back frames with cfg_valid held high throughout
    push(ST_OK, 3'b100, 3, 1'b1, FA);
    send_frame(2'b10, FA, 5);
    push(ST_OK, 3'b001, 3, 1'b1, FE);
    send_frame(2'b00, FE, 5); cfg_valid = 1'b0;
    wait_drain();

    // Reset while the COMMIT strobe is high
    send_frame(2'b00, FB, 5); cfg_valid = 1'b0;
    check("commit_strobe", {en24, en2, en1}, 3'b001);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_commit");
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("no_repeat_strobe", {en24, en2, en1}, 0);
    push(ST_OK, 3'b001, 3, 1'b1, FE);
    send_frame(2'b00, FE, 5); cfg_valid = 1'b0;
    wait_drain();

    // Reset in COLLECT after word 2
    send_frame(2'b01, FA, 3); cfg_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst_collect");
    rst = 1'b0;
    @(posedge clk); #1;
    push(ST_OK, 3'b010, 3, 1'b1, FC);
    send_frame(2'b01, FC, 5); cfg_valid = 1'b0;
    wait_drain();

    check("queue_empty", q.size(), 0);
    check("idle_busy", busy, 0);
    if (Z != 0) bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
